// File: rtl/mem_a_read_fetcher.sv
// mem_a_read_fetcher: queues A-row addresses, issues one read each, packs ARRAY_HEIGHT beats per block
module mem_a_read_fetcher #(
    parameter int BUS_WIDTH_BYTES  = 32,
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int ARRAY_HEIGHT     = 4,
    parameter int ADDR_FIFO_DEPTH  = 8,
    parameter int MEM_LATENCY      = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [15:0]                             a_fifo_addr,
    input  logic                                    a_fifo_incr,
    output logic                                    a_fifo_full,
    output logic                                    mem_rd_en,
    output logic [15:0]                             mem_rd_addr,
    input  logic [BUS_WIDTH_BYTES*8-1:0]              mem_rd_data,
    output logic                                    a_blk_valid,
    input  logic                                    a_blk_ready,
    output logic [ARRAY_HEIGHT*BUS_WIDTH_BYTES*8-1:0] a_blk_data,
    output logic                                    err_overflow,
    output logic                                    busy
);
    localparam int BW  = (BUS_WIDTH_BYTES / DATA_WIDTH_BYTES) * DATA_WIDTH_BYTES * 8;
    localparam int PW  = $clog2(ADDR_FIFO_DEPTH);
    localparam int CNW = PW + 1;
    localparam int SW  = $clog2(ARRAY_HEIGHT);
    localparam int CW  = SW + 1;
    localparam logic [CNW-1:0] DEPTH_C = ADDR_FIFO_DEPTH[CNW-1:0];
    localparam logic [CW-1:0]  AH_C    = ARRAY_HEIGHT[CW-1:0];

    typedef enum logic [1:0] {FILL, DRAIN, HANDOFF} state_t;

    state_t                  state, state_nxt;
    logic [15:0]             fifo_mem [ADDR_FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CNW-1:0]          count;
    logic [CW-1:0]           issued, returned;
    logic [MEM_LATENCY-1:0]  vsr;
    logic [BW-1:0]           asm_buf [ARRAY_HEIGHT];
    logic [ARRAY_HEIGHT*BW-1:0] asm_flat;
    logic                    pop, push, handoff, beat;

    assign a_fifo_full = count == DEPTH_C;
    assign pop         = state == FILL && count != '0 && issued < AH_C;
    assign push        = a_fifo_incr && (!a_fifo_full || pop);
    assign handoff     = state == HANDOFF && (!a_blk_valid || a_blk_ready);
    assign beat        = vsr[MEM_LATENCY-1];
    assign busy        = count != '0 || |vsr || returned != '0 || a_blk_valid;

    for (genvar i = 0; i < ARRAY_HEIGHT; i++) begin : g_flat
        assign asm_flat[i*BW +: BW] = asm_buf[i];
    end

    // address FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr + PW'(push);
            rd_ptr       <= rd_ptr + PW'(pop);
            count        <= count + CNW'(push) - CNW'(pop);
            err_overflow <= err_overflow | (a_fifo_incr & ~push);
        end
    end

    // address FIFO storage
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= a_fifo_addr;
    end

    // next-state logic for the fill/drain/handoff sequence
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (issued == AH_C) state_nxt = DRAIN;
            DRAIN:   if (returned == AH_C) state_nxt = HANDOFF;
            HANDOFF: if (handoff) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // state, read request register, return-valid pipeline and beat counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            vsr         <= '0;
            issued      <= '0;
            returned    <= '0;
        end else begin
            state     <= state_nxt;
            mem_rd_en <= pop;
            if (pop) mem_rd_addr <= fifo_mem[rd_ptr];
            vsr       <= MEM_LATENCY'({vsr, mem_rd_en});
            issued    <= handoff ? '0 : issued + CW'(pop);
            returned  <= handoff ? '0 : returned + CW'(beat);
        end
    end

    // assembly buffer: each returning beat lands in the next slot
    always_ff @(posedge clk) begin
        if (beat) asm_buf[returned[SW-1:0]] <= mem_rd_data;
    end

    // output block register; a reload on handoff wins over a same-cycle accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_blk_valid <= 1'b0;
            a_blk_data  <= '0;
        end else if (handoff) begin
            a_blk_valid <= 1'b1;
            a_blk_data  <= asm_flat;
        end else if (a_blk_ready) begin
            a_blk_valid <= 1'b0;
        end
    end
endmodule
